// File: rtl/depth_tile_buffer.sv
// Tile depth/colour buffer: clears itself, depth-tests a fragment stream into
// on-chip storage, then drains the resolved tile in raster order.
module depth_tile_buffer #(
  parameter int                 TILE_W      = 16,
  parameter int                 TILE_H      = 16,
  parameter int                 COORD_W     = 10,
  parameter int                 DEPTH_W     = 24,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [COORD_W-1:0] tile_origin_x,
  input  logic [COORD_W-1:0] tile_origin_y,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_covered,
  input  logic [DEPTH_W-1:0] s_depth,
  input  logic [COLOR_W-1:0] s_color,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [COLOR_W-1:0] m_color,
  output logic [COORD_W-1:0] m_x,
  output logic [COORD_W-1:0] m_y,
  output logic               m_last,
  output logic               busy
);

  localparam int N  = TILE_W * TILE_H;
  localparam int XW = $clog2(TILE_W);
  localparam int YW = $clog2(TILE_H);
  localparam int AW = XW + YW;

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_ACCEPT = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam logic [DEPTH_W-1:0] FAR_DEPTH = {1'b0, {(DEPTH_W-1){1'b1}}};
  localparam logic [AW-1:0]      LAST_ADDR = AW'(N - 1);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [COORD_W-1:0] origin_x_q, origin_x_d;
  logic [COORD_W-1:0] origin_y_q, origin_y_d;

  logic [DEPTH_W-1:0] depth_mem [N];
  logic [COLOR_W-1:0] color_mem [N];

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [DEPTH_W-1:0] mem_wdepth;
  logic [COLOR_W-1:0] mem_wcolor;

  logic [COORD_W-1:0] frag_col, frag_row;
  logic               frag_in_tile;
  logic [AW-1:0]      frag_addr;
  logic               frag_nearer;
  logic               frag_fire;
  logic               draining;

  // Left/above-origin fragments wrap to large unsigned offsets and fail the bound.
  assign frag_col     = s_x - origin_x_q;
  assign frag_row     = s_y - origin_y_q;
  assign frag_in_tile = (frag_col < COORD_W'(TILE_W)) && (frag_row < COORD_W'(TILE_H));
  assign frag_addr    = {frag_row[YW-1:0], frag_col[XW-1:0]};
  assign frag_nearer  = $signed(s_depth) < $signed(depth_mem[frag_addr]);
  assign frag_fire    = (state_q == ST_ACCEPT) && s_valid;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mem_we     = 1'b0;
    mem_waddr  = cnt_q;
    mem_wdepth = FAR_DEPTH;
    mem_wcolor = CLEAR_COLOR;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (frag_fire && s_covered && frag_in_tile && frag_nearer) begin
      mem_we     = 1'b1;
      mem_waddr  = frag_addr;
      mem_wdepth = s_depth;
      mem_wcolor = s_color;
    end
  end

  // NOTE: the storage arrays are deliberately not reset; CLEAR initialises them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      depth_mem[mem_waddr] <= mem_wdepth;
      color_mem[mem_waddr] <= mem_wcolor;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    origin_x_d = origin_x_q;
    origin_y_d = origin_y_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          origin_x_d = tile_origin_x;
          origin_y_d = tile_origin_y;
        end
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_ACCEPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_ACCEPT: begin
        if (frag_fire && s_last) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      origin_x_q <= '0;
      origin_y_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      origin_x_q <= origin_x_d;
      origin_y_q <= origin_y_d;
    end
  end

  assign draining = (state_q == ST_DRAIN);
  assign s_ready  = (state_q == ST_ACCEPT);
  assign busy     = (state_q != ST_ACCEPT);
  assign m_valid  = draining;
  assign m_last   = draining && (cnt_q == LAST_ADDR);
  assign m_color  = draining ? color_mem[cnt_q] : '0;
  assign m_x      = draining ? origin_x_q + COORD_W'(cnt_q[XW-1:0])  : '0;
  assign m_y      = draining ? origin_y_q + COORD_W'(cnt_q[AW-1:XW]) : '0;

endmodule

// File: tb/tb_depth_tile_buffer.sv
// Randomised and directed bench for depth_tile_buffer on a 4x4 tile, checked
// against an array-based model of the depth test and raster-order drain.
module tb_depth_tile_buffer;

  localparam int TW = 4;
  localparam int TH = 4;
  localparam int N  = TW * TH;
  localparam int CMASK = 1023;
  localparam int FAR = (1 << 23) - 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  tile_origin_x = '0, tile_origin_y = '0;
  logic        s_valid = 1'b0, s_ready, s_covered = 1'b0, s_last = 1'b0;
  logic [23:0] s_depth = '0;
  logic [11:0] s_color = '0;
  logic [9:0]  s_x = '0, s_y = '0;
  logic        m_valid, m_ready = 1'b0, m_last, busy;
  logic [11:0] m_color;
  logic [9:0]  m_x, m_y;

  always #5 clk = ~clk;

  depth_tile_buffer #(
    .TILE_W(TW), .TILE_H(TH), .COORD_W(10), .DEPTH_W(24), .COLOR_W(12), .CLEAR_COLOR(12'h000)
  ) dut (
    .clk(clk), .rstn(rstn),
    .tile_origin_x(tile_origin_x), .tile_origin_y(tile_origin_y),
    .s_valid(s_valid), .s_ready(s_ready), .s_covered(s_covered),
    .s_depth(s_depth), .s_color(s_color), .s_x(s_x), .s_y(s_y), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_color(m_color),
    .m_x(m_x), .m_y(m_y), .m_last(m_last), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference tile: nearest depth and its colour per pixel, plus the latched origin.
  int ref_depth [N];
  int ref_color [N];
  int ox, oy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear(input int x, input int y);
    for (int i = 0; i < N; i++) begin
      ref_depth[i] = FAR;
      ref_color[i] = 0;
    end
    ox = x;
    oy = y;
  endfunction

  task automatic apply_reset(input int x, input int y);
    rstn    = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 1);
    check("rst_m_color", m_color, 0);
    check("rst_m_xy", {m_x, m_y}, 0);
    tile_origin_x = x[9:0];
    tile_origin_y = y[9:0];
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Count CLEAR cycles until the buffer accepts; origin is changed after the
  // first cycle so a late re-sample would show up in the drained coordinates.
  task automatic wait_clear(input int x, input int y);
    int n = 0;
    tile_origin_x = x[9:0];
    tile_origin_y = y[9:0];
    model_clear(x, y);
    check("clear_busy", busy, 1);
    while (!s_ready && n < 100) begin
      tick();
      n++;
      if (n == 1) begin
        tile_origin_x = 10'($urandom);
        tile_origin_y = 10'($urandom);
      end
    end
    check("clear_len", n, 16);
    check("accept_busy", busy, 0);
  endtask

  task automatic send(input bit cov, input int d, input int c, input int x, input int y, input bit last);
    int col, row;
    check("frag_ready", s_ready, 1);
    s_valid   = 1'b1;
    s_covered = cov;
    s_depth   = d[23:0];
    s_color   = c[11:0];
    s_x       = x[9:0];
    s_y       = y[9:0];
    s_last    = last;
    col = (x - ox) & CMASK;
    row = (y - oy) & CMASK;
    if (cov && col < TW && row < TH && d < ref_depth[row*TW + col]) begin
      ref_depth[row*TW + col] = d;
      ref_color[row*TW + col] = c & 12'hFFF;
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // mode 0: m_ready high; 1: pattern 1,0,0,1; 2: random. abort_at >= 0 stops before that pixel.
  task automatic drain(input int mode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit r;
    while (idx < N && cyc < 400) begin
      if (abort_at >= 0 && idx == abort_at) break;
      check("drain_valid", m_valid, 1);
      check("drain_ready_low", s_ready, 0);
      check("drain_color", m_color, ref_color[idx]);
      check("drain_x", m_x, (ox + idx % TW) & CMASK);
      check("drain_y", m_y, (oy + idx / TW) & CMASK);
      check("drain_last", m_last, idx == N - 1);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_ready = r;
      tick();
      if (r) idx++;
      cyc++;
    end
    m_ready = 1'b0;
    if (abort_at < 0) begin
      check("drain_count", idx, N);
      check("drain_done_valid", m_valid, 0);
    end
  endtask

  function automatic int rand_depth();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return FAR;
    if (r == 1) return -(1 << 23);
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  initial begin
    int nfr, x0, y0;

    // Power-up clear and an empty tile drained by one uncovered last fragment.
    apply_reset(8, 4);
    wait_clear(8, 4);
    send(1'b0, 0, 0, 8, 4, 1'b1);
    drain(0, -1);

    // Nearest wins; equal depth keeps the first writer.
    wait_clear(8, 4);
    send(1'b1, 100, 'hF00, 9, 5, 1'b0);
    send(1'b1, 50, 'h0F0, 9, 5, 1'b0);
    send(1'b1, 50, 'h00F, 9, 5, 1'b1);
    drain(0, -1);

    // Just outside each tile edge: all dropped.
    wait_clear(8, 4);
    send(1'b1, -5, 'h111, 7, 4, 1'b0);
    send(1'b1, -5, 'h222, 12, 4, 1'b0);
    send(1'b1, -5, 'h333, 8, 3, 1'b0);
    send(1'b1, -5, 'h444, 8, 8, 1'b1);
    drain(0, -1);

    // Uncovered nearer fragment ignored; drain with stalled m_ready.
    wait_clear(8, 4);
    send(1'b1, -1, 'hABC, 10, 6, 1'b0);
    send(1'b0, -100, 'h123, 10, 6, 1'b1);
    drain(1, -1);

    // Reset in the middle of a drain, then a fresh tile with no stale data.
    wait_clear(8, 4);
    send(1'b1, -7, 'h5A5, 8, 4, 1'b0);
    send(1'b1, 3, 'hC3C, 11, 7, 1'b1);
    drain(0, 5);
    apply_reset(16, 8);
    wait_clear(16, 8);
    send(1'b1, 10, 'h777, 17, 9, 1'b0);
    send(1'b0, 0, 0, 0, 0, 1'b1);
    drain(2, -1);

    // Random tiles, including origins that wrap the coordinate space.
    for (int t = 0; t < 8; t++) begin
      x0 = (t == 0) ? 1022 : int'($urandom_range(0, 1023));
      y0 = (t == 1) ? 1021 : int'($urandom_range(0, 1023));
      wait_clear(x0, y0);
      nfr = int'($urandom_range(1, 40));
      for (int f = 0; f < nfr; f++) begin
        send(1'($urandom_range(0, 3) != 0), rand_depth(), int'($urandom_range(0, 4095)),
             (x0 + int'($urandom_range(0, 7)) - 2) & CMASK,
             (y0 + int'($urandom_range(0, 7)) - 2) & CMASK, f == nfr - 1);
      end
      drain(2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
